// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 mouse command sequencer and packet assembler.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ps2_pkg;

  // Host-to-mouse commands
  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_EN_STREAM = 8'hF4;

  // Mouse-to-host responses
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;

  // Bit positions inside stream packet byte 0
  localparam int B0_BTN_LSB = 0;
  localparam int B0_BTN_MSB = 2;
  localparam int B0_SYNC    = 3;  // always 1 in a well-formed byte 0
  localparam int B0_XSIGN   = 4;
  localparam int B0_YSIGN   = 5;
  localparam int B0_XOVF    = 6;
  localparam int B0_YOVF    = 7;

  // Command/response sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_STREAM,
    ST_FAIL
  } ctrl_state_t;

  // Stream packet byte position
  typedef enum logic [1:0] {
    PKT_B0,
    PKT_B1,
    PKT_B2
  } pkt_state_t;

endpackage

// File: rtl/ps2_pkt_asm.sv
// Assembles 3-byte PS/2 stream packets into buttons, 9-bit dx/dy and overflow flags.
// Latency: outputs and pkt_tick update one cycle after the third byte's rx_done_tick.
// Backpressure: none; every byte is consumed. PS2M_SYNC_CHECK_EN drops byte-0 candidates with bit3=0.
module ps2_pkt_asm
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  output logic       pkt_tick,
  output logic [2:0] btn,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [1:0] ovf
);

  pkt_state_t st, st_n;
  logic [2:0] b0_btn;
  logic       b0_xs;
  logic       b0_ys;
  logic [1:0] b0_ovf;
  logic [7:0] b1;
  logic       rx_ok;
  logic       b0_ok;

  assign rx_ok = en && rx_done_tick;

`ifdef PS2M_SYNC_CHECK_EN
  // A byte without the always-one bit cannot start a packet; dropping it realigns the stream.
  assign b0_ok = rx_dout[B0_SYNC];
`else
  assign b0_ok = 1'b1;
`endif

  // Byte-position register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= PKT_B0;
    else       st <= st_n;
  end

  // Advance one position per accepted byte; hold at B0 while streaming is not enabled
  always_comb begin
    st_n = st;
    if (!en) begin
      st_n = PKT_B0;
    end else if (rx_done_tick) begin
      case (st)
        PKT_B0:  if (b0_ok) st_n = PKT_B1;
        PKT_B1:  st_n = PKT_B2;
        PKT_B2:  st_n = PKT_B0;
        default: st_n = PKT_B0;
      endcase
    end
  end

  // Capture bytes 0/1 and publish the complete packet on byte 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b0_btn   <= '0;
      b0_xs    <= 1'b0;
      b0_ys    <= 1'b0;
      b0_ovf   <= '0;
      b1       <= '0;
      pkt_tick <= 1'b0;
      btn      <= '0;
      dx       <= '0;
      dy       <= '0;
      ovf      <= '0;
    end else begin
      pkt_tick <= 1'b0;
      if (rx_ok) begin
        case (st)
          PKT_B0: begin
            if (b0_ok) begin
              b0_btn <= rx_dout[B0_BTN_MSB:B0_BTN_LSB];
              b0_xs  <= rx_dout[B0_XSIGN];
              b0_ys  <= rx_dout[B0_YSIGN];
              b0_ovf <= {rx_dout[B0_YOVF], rx_dout[B0_XOVF]};
            end
          end
          PKT_B1: b1 <= rx_dout;
          PKT_B2: begin
            btn      <= b0_btn;
            dx       <= {b0_xs, b1};
            dy       <= {b0_ys, rx_dout};
            ovf      <= b0_ovf;
            pkt_tick <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse init sequencer (reset, BAT/ID check, enable streaming with retries) plus packet output.
// Latency: wr_ps2 is combinational from SEND && tx_idle; init_done one cycle after the final ACK.
// Backpressure: waits on tx_idle before each command; optional PS2M_SYNC_CHECK_EN enables byte-0 sync check.
module ps2_mouse_ctrl
  import ps2_pkg::*;
#(
  parameter int MAX_RETRY  = 3,
  parameter int SKIP_RESET = 0
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] din,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  output logic       rx_en,
  output logic       init_done,
  output logic       init_fail,
  output logic       pkt_tick,
  output logic [2:0] btn,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [1:0] ovf
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  ctrl_state_t   state, state_n;
  logic [7:0]    cmd, cmd_n;
  logic [RW-1:0] retry_cnt, retry_n;
  logic          rx_ok;

  // Receiver is muted from the write strobe until the transmitter reports completion
  assign rx_en     = !((state == ST_SEND && tx_idle) || state == ST_WAIT_TX);
  assign rx_ok     = rx_done_tick && rx_en;
  assign init_done = (state == ST_STREAM);
  assign init_fail = (state == ST_FAIL);

  // State, current command and retry counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd       <= CMD_RESET;
      retry_cnt <= '0;
    end else begin
      state     <= state_n;
      cmd       <= cmd_n;
      retry_cnt <= retry_n;
    end
  end

  // Command/response sequencing and transmitter write strobe
  always_comb begin
    state_n = state;
    cmd_n   = cmd;
    retry_n = retry_cnt;
    wr_ps2  = 1'b0;
    din     = 8'h00;
    case (state)
      ST_IDLE: begin
        state_n = ST_SEND;
        cmd_n   = (SKIP_RESET != 0) ? CMD_EN_STREAM : CMD_RESET;
        retry_n = '0;
      end
      ST_SEND: begin
        if (tx_idle) begin
          wr_ps2  = 1'b1;
          din     = cmd;
          state_n = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (tx_done_tick) state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (rx_ok) begin
          if (rx_dout == RSP_ACK) begin
            retry_n = '0;
            state_n = (cmd == CMD_RESET) ? ST_WAIT_BAT : ST_STREAM;
          end else if (retry_cnt < MAX_R) begin
            retry_n = retry_cnt + RW'(1);
            state_n = ST_SEND;
          end else begin
            state_n = ST_FAIL;
          end
        end
      end
      ST_WAIT_BAT: begin
        // RSP_BAT_ERR and anything else unexpected is fatal
        if (rx_ok) state_n = (rx_dout == RSP_BAT_OK) ? ST_WAIT_ID : ST_FAIL;
      end
      ST_WAIT_ID: begin
        if (rx_ok) begin
          cmd_n   = CMD_EN_STREAM;
          state_n = ST_SEND;
        end
      end
      ST_STREAM: state_n = ST_STREAM;
      ST_FAIL:   state_n = ST_FAIL;
      default:   state_n = ST_IDLE;
    endcase
  end

  ps2_pkt_asm u_pkt_asm (
    .clk          (clk),
    .reset        (reset),
    .en           (init_done),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .pkt_tick     (pkt_tick),
    .btn          (btn),
    .dx           (dx),
    .dy           (dy),
    .ovf          (ovf)
  );

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Self-checking bench for ps2_mouse_ctrl: init, retry, failure, handshake, packets, reset.
// Latency: n/a (testbench).
// Backpressure: transmitter model holds tx_idle low while a byte is in flight.
module tb_ps2_mouse_ctrl;

  localparam int TX_LAT = 8;
  localparam int BUDGET = 500;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_idle;
  logic       tx_ready;
  logic       hold_idle;
  logic       tx_done_tick;
  logic       wr_ps2;
  logic [7:0] din;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       rx_en;
  logic       init_done;
  logic       init_fail;
  logic       pkt_tick;
  logic [2:0] btn;
  logic [8:0] dx;
  logic [8:0] dy;
  logic [1:0] ovf;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int f4_count = 0;
  int pkt_count = 0;
  int exp_pkts = 0;
  bit in_tx = 1'b0;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         btn;
    int         dx, dy;
    int         ovf;
  } vec_t;
  vec_t tbl[6];

  assign tx_idle = tx_ready && !hold_idle;

  always #5 clk = ~clk;

  ps2_mouse_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rx_en        (rx_en),
    .init_done    (init_done),
    .init_fail    (init_fail),
    .pkt_tick     (pkt_tick),
    .btn          (btn),
    .dx           (dx),
    .dy           (dy),
    .ovf          (ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy for TX_LAT cycles after each write, then a done pulse
  initial begin
    tx_ready     = 1'b1;
    tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_ps2 === 1'b1 && reset === 1'b0) begin
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (TX_LAT) @(posedge clk);
        #1 tx_done_tick = 1'b1;
        @(posedge clk); #1 tx_done_tick = 1'b0;
        tx_ready = 1'b1;
      end
    end
  end

  // Protocol monitor: never write while busy; receiver muted from write until tx done
  always @(negedge clk) begin
    if (reset) begin
      in_tx = 1'b0;
    end else begin
      chk("rx_en_window", int'(rx_en), int'(!(wr_ps2 || in_tx)));
      if (wr_ps2) begin
        wr_count++;
        if (din == 8'hF4) f4_count++;
        chk("wr_only_when_idle", int'(tx_idle), 1);
        in_tx = 1'b1;
      end
      if (tx_done_tick) in_tx = 1'b0;
      if (pkt_tick) pkt_count++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_dout = b; rx_done_tick = 1'b1;
    @(posedge clk); #1 rx_done_tick = 1'b0;
  endtask

  // Wait for one command write, check its byte, then wait for the transmitter to finish
  task automatic expect_cmd(input logic [7:0] exp, input bit inject);
    int n;
    n = 0;
    @(negedge clk);
    while (wr_ps2 !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    chk("wr_seen", int'(wr_ps2), 1);
    if (wr_ps2 !== 1'b1) return;
    chk("din", int'(din), int'(exp));
    if (inject) send_byte(8'hFE);  // arrives while the receiver is muted
    n = 0;
    while (tx_done_tick !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    chk("tx_done_seen", int'(tx_done_tick), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic reset_bat_id();
    expect_cmd(8'hFF, 1'b0);
    send_byte(8'hFA);
    send_byte(8'hAA);
    send_byte(8'h00);
  endtask

  task automatic check_pkt(input logic [7:0] b0, b1, b2, input int e_btn, e_dx, e_dy, e_ovf);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    @(negedge clk);
    chk("pkt_tick_hi", int'(pkt_tick), 1);
    chk("btn", int'(btn), e_btn);
    chk("dx", int'($signed(dx)), e_dx);
    chk("dy", int'($signed(dy)), e_dy);
    chk("ovf", int'(ovf), e_ovf);
    exp_pkts++;
    @(negedge clk);
    chk("pkt_tick_lo", int'(pkt_tick), 0);
  endtask

  // Reference: decode a packet straight from the byte layout
  function automatic vec_t model_pkt(input logic [7:0] b0, b1, b2);
    vec_t v;
    v.b0  = b0; v.b1 = b1; v.b2 = b2;
    v.btn = int'(b0) % 8;
    v.dx  = (((int'(b0) / 16) % 2) == 1) ? int'(b1) - 256 : int'(b1);
    v.dy  = (((int'(b0) / 32) % 2) == 1) ? int'(b2) - 256 : int'(b2);
    v.ovf = (int'(b0) / 64) % 4;
    return v;
  endfunction

  initial begin
    #600us;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, f4base, pbase, hx;
    vec_t v;
    tbl[0] = '{8'h38, 8'h05, 8'hF0, 0, -251, -16, 0};
    tbl[1] = '{8'hC9, 8'h7F, 8'h80, 1,  127, 128, 3};
    tbl[2] = '{8'h3F, 8'hFF, 8'hFF, 7,   -1,  -1, 0};
    tbl[3] = '{8'h18, 8'h00, 8'h00, 0, -256,   0, 0};
    tbl[4] = '{8'h6A, 8'h00, 8'h01, 2,    0, -255, 1};
    tbl[5] = '{8'h8C, 8'h80, 8'h7F, 4,  128, 127, 2};

    reset = 1'b1; hold_idle = 1'b1; rx_done_tick = 1'b0; rx_dout = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ps2", int'(wr_ps2), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_rx_en", int'(rx_en), 1);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_init_fail", int'(init_fail), 0);
    chk("rst_pkt_tick", int'(pkt_tick), 0);
    chk("rst_btn", int'(btn), 0);
    chk("rst_dx", int'(dx), 0);
    chk("rst_dy", int'(dy), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(posedge clk); #1 reset = 1'b0;

    // Handshake: transmitter busy for 50 cycles, no write may appear
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("hold_no_wr", wr_count, 0);
    chk("hold_rx_en", int'(rx_en), 1);
    @(posedge clk); #1 hold_idle = 1'b0;

    // Normal init, with a stray byte while the receiver is muted
    base = wr_count;
    expect_cmd(8'hFF, 1'b1);
    send_byte(8'hFA);
    send_byte(8'hAA);
    send_byte(8'h00);
    expect_cmd(8'hF4, 1'b0);
    chk("init_done_before_ack", int'(init_done), 0);
    send_byte(8'hFA);
    @(negedge clk);
    chk("init_done", int'(init_done), 1);
    chk("init_fail_normal", int'(init_fail), 0);
    chk("init_wr_pulses", wr_count - base, 2);

    // Table-driven packets
    for (int i = 0; i < 6; i++)
      check_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].btn, tbl[i].dx, tbl[i].dy, tbl[i].ovf);

    // Randomized packets against the reference decode
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      v = model_pkt(8'($urandom_range(0, 255)) | 8'h08, 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)));
      check_pkt(v.b0, v.b1, v.b2, v.btn, v.dx, v.dy, v.ovf);
    end

    // Outputs hold between packets
    hx = int'($signed(dx));
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("dx_hold", int'($signed(dx)), hx);
    chk("no_wr_in_stream", wr_count - base, 2);

`ifdef PS2M_SYNC_CHECK_EN
    send_byte(8'h00);
    check_pkt(8'h09, 8'h01, 8'h02, 1, 1, 2, 0);
`else
    check_pkt(8'h00, 8'h09, 8'h01, 0, 9, 1, 0);
`endif

    // Reset in the middle of a packet
    send_byte(8'h3F);
    send_byte(8'h11);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("midrst_dx", int'(dx), 0);
    chk("midrst_dy", int'(dy), 0);
    chk("midrst_btn", int'(btn), 0);
    chk("midrst_init_done", int'(init_done), 0);
    @(posedge clk); #1 reset = 1'b0;

    // Retry: first F4 refused, second accepted
    base = wr_count;
    reset_bat_id();
    expect_cmd(8'hF4, 1'b0);
    send_byte(8'hFE);
    expect_cmd(8'hF4, 1'b0);
    send_byte(8'hFA);
    @(negedge clk);
    chk("retry_init_done", int'(init_done), 1);
    chk("retry_wr_pulses", wr_count - base, 3);
    check_pkt(tbl[0].b0, tbl[0].b1, tbl[0].b2, tbl[0].btn, tbl[0].dx, tbl[0].dy, tbl[0].ovf);

    // Failure: every F4 refused
    do_reset();
    base = wr_count; f4base = f4_count;
    reset_bat_id();
    for (int i = 0; i < 4; i++) begin
      expect_cmd(8'hF4, 1'b0);
      if (i == 3) chk("fail_not_early", int'(init_fail), 0);
      send_byte(8'hFE);
    end
    @(negedge clk);
    chk("fail_init_fail", int'(init_fail), 1);
    chk("fail_init_done", int'(init_done), 0);
    chk("fail_f4_pulses", f4_count - f4base, 4);
    pbase = pkt_count;
    repeat (100) @(posedge clk);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("fail_no_more_wr", wr_count - base, 5);
    chk("fail_rx_ignored", pkt_count - pbase, 0);
    chk("fail_sticky", int'(init_fail), 1);

    // BAT error
    do_reset();
    base = wr_count;
    expect_cmd(8'hFF, 1'b0);
    send_byte(8'hFA);
    send_byte(8'hFC);
    @(negedge clk);
    chk("bat_fail", int'(init_fail), 1);
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("bat_no_more_wr", wr_count - base, 1);

    chk("pkt_count", pkt_count, exp_pkts);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_ctrl.md
Name: ps2_mouse_ctrl

Overview:
- Mouse-side command/response sequencer sitting directly upstream of the PS/2 transmitter, alongside the PS/2 receiver.
- After reset it drives the transmitter's wr_ps2/din handshake to issue the reset (0xFF) and enable-streaming (0xF4) commands, and checks the mouse responses from the receiver.
- It then assembles 3-byte stream packets into button, 9-bit two's-complement dx/dy and overflow outputs for the display/cursor logic.

Parameters:
- MAX_RETRY, 3: number of resends allowed per command on a non-ACK response before the block enters FAIL.
- SKIP_RESET, 0: when 1, skip 0xFF/BAT/ID and send only 0xF4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tx_idle  in  1  transmitter idle (1 = ready to accept wr_ps2)
- tx_done_tick  in  1  one-cycle pulse: transmitter finished a byte
- wr_ps2  out  1  one-cycle write strobe to transmitter
- din  out  8  command byte to transmitter; valid while wr_ps2=1
- rx_done_tick  in  1  one-cycle pulse: receiver byte valid
- rx_dout  in  8  received byte
- rx_en  out  1  receiver enable; 0 from wr_ps2 until tx_done_tick
- init_done  out  1  level: streaming enabled
- init_fail  out  1  level: retries exhausted or BAT failure
- pkt_tick  out  1  one-cycle pulse: new packet on outputs
- btn  out  3  {middle, right, left}
- dx  out  9  X movement, two's complement
- dy  out  9  Y movement, two's complement
- ovf  out  2  {y_ovf, x_ovf}

Behaviour:
- Reset values: wr_ps2=0, din=0x00, rx_en=1, init_done=0, init_fail=0, pkt_tick=0, btn=0, dx=0, dy=0, ovf=0, retry count=0; state=IDLE.
- IDLE: next cycle go to SEND with cmd=0xFF, or with cmd=0xF4 if SKIP_RESET=1.
- SEND: wait for tx_idle=1. Then pulse wr_ps2 for exactly one cycle with din=cmd, drop rx_en, go to WAIT_TX. Never pulse while tx_idle=0.
- WAIT_TX: on tx_done_tick set rx_en=1 and go to WAIT_ACK.
- WAIT_ACK, on rx_done_tick:
  - 0xFA: clear retry count; go to WAIT_BAT if cmd=0xFF, else to STREAM_B0 with init_done=1.
  - Any other byte: if retry count < MAX_RETRY, increment it and return to SEND with the same cmd; otherwise go to FAIL.
- WAIT_BAT, on rx_done_tick:
  - 0xAA: go to WAIT_ID.
  - Any other byte (including 0xFC): go to FAIL.
- WAIT_ID: the next received byte (any value) moves to SEND with cmd=0xF4.
- STREAM_B0 -> B1 -> B2, one received byte per state:
  - B0 latches byte 0 into an internal register.
  - B1 latches byte 1.
  - On B2's rx_done_tick at cycle N, at edge N+1 register:
    - btn = b0[2:0]
    - dx = {b0[4], b1}
    - dy = {b0[5], rx_dout}
    - ovf = {b0[7], b0[6]}
  - pkt_tick is high for exactly cycle N+1; return to B0.
  - Outputs hold between packets.
- FAIL: terminal; init_fail=1 and init_done=0 until reset. No further wr_ps2; rx bytes ignored.
- rx_done_tick while rx_en=0, or in IDLE/SEND/WAIT_TX: ignored.
- Reset mid-operation: immediately return to reset values; the sequence restarts from IDLE, and any partial packet is discarded.
- The block never issues wr_ps2 in STREAM states.

Optional Feature:
- PS2M_SYNC_CHECK_EN defined: in STREAM_B0 a byte with bit3=0 is discarded and the state stays B0; realigns after a lost byte.
- Undefined: any byte is accepted as byte 0.

Decomposition:
- Shared package ps2_pkg holds:
  - command constants CMD_RESET=0xFF, CMD_EN_STREAM=0xF4
  - response constants RSP_ACK=0xFA, RSP_BAT_OK=0xAA, RSP_BAT_ERR=0xFC
  - the state enumeration
  - packet byte-0 bit indices
- One natural sub-module: ps2_pkt_asm (the 3-byte STREAM_B0/B1/B2 assembler plus output registers), enabled by init_done.

Test Plan:
- Normal init:
  - Stimulus: model responds FA, AA, 00 to 0xFF, then FA to 0xF4.
  - Required: exactly two wr_ps2 pulses with din=0xFF then 0xF4; init_done=1 one cycle after the final FA; init_fail=0.
- Retry:
  - Stimulus: first 0xF4 answered with FE, second with FA.
  - Required: three wr_ps2 pulses in total; init_done=1.
- Failure:
  - Stimulus: every 0xF4 answered with FE (MAX_RETRY=3).
  - Required: four 0xF4 pulses, then init_fail=1 and no further wr_ps2.
- Packet:
  - Stimulus: bytes 0x38, 0x05, 0xF0.
  - Required: pkt_tick one cycle after the third byte; btn=000, dx=0x105 (-251), dy=0x1F0 (-16), ovf=00.
- Handshake:
  - Stimulus: tx_idle held 0 for 50 cycles in SEND.
  - Required: no wr_ps2 until tx_idle=1; rx_en=0 from the wr_ps2 pulse until tx_done_tick.
- Sync (PS2M_SYNC_CHECK_EN defined):
  - Stimulus: 0x00, 0x09, 0x01, 0x02.
  - Required: 0x00 discarded; one packet with btn=001, dx=1, dy=2.
